// File: rtl/proj_pkg.sv
// Shared constants and types for the projection pipeline.
// This slice holds the min-hash sorter's table entry type.
package proj_pkg;

  localparam int INDICE_LEN                    = 5;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int SORTER_HASH_LEN               = 16;

  typedef struct packed {
    logic                       valid;
    logic [SORTER_HASH_LEN-1:0] hash;
    logic [INDICE_LEN-1:0]      index;
  } sorter_entry_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } sorter_state_t;

endpackage

// File: rtl/proj_minhash_sorter_if.sv
// Hash stream in, position array out; master is the upstream/extender side.
interface proj_minhash_sorter_if #(
  parameter int HASH_LEN      = 16,
  parameter int INDICE_LEN    = 5,
  parameter int INDICES_COUNT = 4
);
  logic                              in_valid;
  logic [HASH_LEN-1:0]               in_hash;
  logic                              in_last;
  logic                              in_ready;
  logic                              out_valid;
  logic                              out_ready;
  logic [INDICES_COUNT*INDICE_LEN-1:0] out_kmer_indices;
  logic [$clog2(INDICES_COUNT+1)-1:0]  out_count;
  logic                              out_err;

  modport master (
    output in_valid, in_hash, in_last, out_ready,
    input  in_ready, out_valid, out_kmer_indices, out_count, out_err
  );

  modport slave (
    input  in_valid, in_hash, in_last, out_ready,
    output in_ready, out_valid, out_kmer_indices, out_count, out_err
  );
endinterface

// File: rtl/proj_sorter_cell.sv
// One slot of the sorted shift-register table. take marks where the new hash
// belongs; a slot whose upstream neighbour also takes shifts that entry down.
module proj_sorter_cell
  import proj_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          insert_en,
  input  sorter_entry_t new_entry,
  input  sorter_entry_t up_entry,
  input  logic          up_take,
  output sorter_entry_t entry,
  output logic          take
);
  sorter_entry_t entry_reg;

  // Strict less-than keeps an earlier equal hash in front of a later one.
  assign take  = !entry_reg.valid || (new_entry.hash < entry_reg.hash);
  assign entry = entry_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      entry_reg <= '0;
    end else if (insert_en && take) begin
      entry_reg <= up_take ? up_entry : new_entry;
    end
  end
endmodule

// File: rtl/proj_minhash_sorter.sv
// Streaming min-k selector: keeps the smallest hashes of a fragment with their
// positions and hands the position array to the extender at fragment end.
module proj_minhash_sorter
  import proj_pkg::*;
#(
  parameter int HASH_LEN      = SORTER_HASH_LEN,
  parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
  parameter int INDICES_COUNT = SORTER_EXTENDER_INDICES_COUNT
) (
  input logic                  clk,
  input logic                  rst,
  proj_minhash_sorter_if.slave bus
);
  localparam int CNT_W = $clog2(INDICES_COUNT + 1);
  localparam logic [INDICE_LEN-1:0] POS_MAX = '1;

  sorter_state_t         state_reg, state_next;
  logic [INDICE_LEN-1:0] pos_reg;
  logic                  err_reg;
  logic [HASH_LEN-1:0]   hash_w;
  logic                  accept, handshake;
  sorter_entry_t         new_entry;
  sorter_entry_t         entry_arr [INDICES_COUNT];
  logic                  take_arr  [INDICES_COUNT];

  assign hash_w    = bus.in_hash;
  assign accept    = bus.in_valid && (state_reg == COLLECT);
  assign handshake = bus.out_ready && (state_reg == HOLD);
  assign new_entry = '{valid: 1'b1, hash: hash_w, index: pos_reg};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (accept && bus.in_last) state_next = HOLD;
      HOLD:    if (bus.out_ready)         state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg <= '0;
      err_reg <= 1'b0;
    end else if (handshake) begin
      pos_reg <= '0;
    end else if (accept) begin
      if (pos_reg == POS_MAX) begin
        if (!bus.in_last) err_reg <= 1'b1;
      end else begin
        pos_reg <= pos_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < INDICES_COUNT; gi++) begin : g_cell
    sorter_entry_t up_entry;
    logic          up_take;
    if (gi == 0) begin : g_head
      assign up_entry = '0;
      assign up_take  = 1'b0;
    end else begin : g_link
      assign up_entry = entry_arr[gi-1];
      assign up_take  = take_arr[gi-1];
    end
    proj_sorter_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (handshake),
      .insert_en (accept),
      .new_entry (new_entry),
      .up_entry  (up_entry),
      .up_take   (up_take),
      .entry     (entry_arr[gi]),
      .take      (take_arr[gi])
    );
  end

  // Invalid slots may carry shifted-in leftovers, so mask them to zero.
  logic [INDICES_COUNT*INDICE_LEN-1:0] indices_next;
  logic [CNT_W-1:0]                    count_next;
  always_comb begin
    indices_next = '0;
    count_next   = '0;
    for (int i = 0; i < INDICES_COUNT; i++) begin
      if (entry_arr[i].valid) begin
        indices_next[i*INDICE_LEN +: INDICE_LEN] = entry_arr[i].index;
        count_next = count_next + 1'b1;
      end
    end
  end

  assign bus.in_ready         = (state_reg == COLLECT);
  assign bus.out_valid        = (state_reg == HOLD);
  assign bus.out_kmer_indices = indices_next;
  assign bus.out_count        = count_next;
  assign bus.out_err          = err_reg;
endmodule

// File: tb/tb_proj_minhash_sorter.sv
// Directed bench for proj_minhash_sorter with hand-computed expectations.
module tb_proj_minhash_sorter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  proj_minhash_sorter_if #(.HASH_LEN(16), .INDICE_LEN(5), .INDICES_COUNT(4)) bus ();

  proj_minhash_sorter #(.HASH_LEN(16), .INDICE_LEN(5), .INDICES_COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic push(input logic [15:0] h, input logic last);
    bus.in_valid = 1'b1;
    bus.in_hash  = h;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_pop: out_valid=%b in_ready=%b required 0 1", name, bus.out_valid, bus.in_ready);
    end
    $display("pop   %s", name);
  endtask

  task automatic check_out(input string name, input logic [19:0] idx, input logic [2:0] cnt);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.out_kmer_indices !== idx || bus.out_count !== cnt) begin
      failures++;
      $display("FAIL %s: valid=%b ready=%b idx=%h cnt=%0d required valid=1 ready=0 idx=%h cnt=%0d",
               name, bus.out_valid, bus.in_ready, bus.out_kmer_indices, bus.out_count, idx, cnt);
    end
    $display("frag  %s idx=%h cnt=%0d", name, bus.out_kmer_indices, bus.out_count);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_kmer_indices !== 20'd0 ||
        bus.out_count !== 3'd0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b idx=%h cnt=%0d err=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_kmer_indices, bus.out_count, bus.out_err);
    end
    $display("reset ready=%b valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_basic();
    logic [15:0] hs [5] = '{16'd50, 16'd20, 16'd40, 16'd10, 16'd30};
    for (int i = 0; i < 5; i++) push(hs[i], i == 4);
    check_out("basic", {5'd2, 5'd4, 5'd1, 5'd3}, 3'd4);
    pop("basic");
  endtask

  task automatic test_ties();
    for (int i = 0; i < 5; i++) push(16'd7, i == 4);
    check_out("ties", {5'd3, 5'd2, 5'd1, 5'd0}, 3'd4);
    pop("ties");
  endtask

  task automatic test_short();
    push(16'd9, 1'b0);
    push(16'd3, 1'b1);
    check_out("short", 20'd1, 3'd2);
    pop("short");
    push(16'd42, 1'b1);
    check_out("single", 20'd0, 3'd1);
    pop("single");
  endtask

  task automatic test_back_to_back();
    logic [19:0] held;
    push(16'd11, 1'b0);
    push(16'd12, 1'b0);
    push(16'd13, 1'b1);
    held = {5'd0, 5'd2, 5'd1, 5'd0};
    bus.in_valid = 1'b1;
    bus.in_hash  = 16'd1;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_out($sformatf("stall%0d", c), held, 3'd3);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL recover: valid=%b ready=%b cnt=%0d required 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_count);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_out("next_first", 20'd0, 3'd1);
    pop("next_first");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin
      push(16'(100 - i), 1'b0);
      if (i == 30 || i == 31) begin
        checks++;
        if (bus.out_err !== (i == 31)) begin
          failures++;
          $display("FAIL overflow_err%0d: err=%b required %b", i, bus.out_err, (i == 31));
        end
      end
    end
    push(16'd68, 1'b1);
    check_out("overflow", {5'd29, 5'd30, 5'd31, 5'd31}, 3'd4);
    checks++;
    if (bus.out_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: err=%b required 1", bus.out_err);
    end
    do_reset();
    checks++;
    if (bus.out_err !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL overflow_rst: err=%b valid=%b ready=%b required 0 0 1",
               bus.out_err, bus.out_valid, bus.in_ready);
    end
    $display("ovf   err cleared=%b", !bus.out_err);
  endtask

  task automatic test_mid_reset();
    push(16'd2, 1'b0);
    push(16'd4, 1'b0);
    push(16'd6, 1'b0);
    do_reset();
    checks++;
    if (bus.out_count !== 3'd0 || bus.out_kmer_indices !== 20'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst: cnt=%0d idx=%h valid=%b required 0 0 0",
               bus.out_count, bus.out_kmer_indices, bus.out_valid);
    end
    push(16'd5, 1'b0);
    push(16'd1, 1'b1);
    check_out("after_midrst", 20'd1, 3'd2);
    pop("after_midrst");
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_hash   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_ties();
    test_short();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
